axis_cmd_bridge: RTL and testbench
==================================

# axis_cmd_bridge

Command front-end for `axilite_master`. It takes register-access commands packed as AXI-Stream frames and runs one backend write or read at a time through the `bk_*` strobes. Read results go back as single-beat AXI-Stream responses. The block sits directly upstream of `axilite_master` in the FSIC user-project config path, and both blocks share one clock.

## Interface
Parameters:
- none (32-bit data and address are fixed to match the `bk_*` interface)

Ports:
- `axi_aclk`  in  1  clock; shared with the downstream master.
- `axi_aresetn`  in  1  reset; asynchronous, active-low.
- `s_axis_tdata`  in  32  command beat.
- `s_axis_tvalid`  in  1  command beat valid.
- `s_axis_tlast`  in  1  last beat of the command frame.
- `s_axis_tready`  out  1  command beat accepted.
- `m_axis_tdata`  out  32  read response data.
- `m_axis_tvalid`  out  1  response valid.
- `m_axis_tlast`  out  1  response last; always equal to `m_axis_tvalid`.
- `m_axis_tready`  in  1  response accepted.
- `bk_wstart`  out  1  single-cycle write-start pulse.
- `bk_waddr`  out  32  write address.
- `bk_wdata`  out  32  write data.
- `bk_wstrb`  out  4  write byte strobes.
- `bk_wdone`  in  1  write-complete pulse.
- `bk_rstart`  out  1  single-cycle read-start pulse.
- `bk_raddr`  out  32  read address.
- `bk_rdata`  in  32  read data; valid in the `bk_rdone` cycle.
- `bk_rdone`  in  1  read-complete pulse.
- `busy`  out  1  high in any state other than HDR.
- `err_cnt`  out  8  count of malformed frames; saturates at 255.

## Operation
Frame format:
- Beat 0 is the header.
  - [31] op: 1 = write, 0 = read.
  - [3:0] wstrb.
  - All other bits are reserved and ignored.
- Beat 1 is the address.
- Beat 2 is the write data. Write frames only.
- A read frame is exactly 2 beats; a write frame is exactly 3 beats. `tlast` is set only on the final beat.

FSM states: HDR, ADDR, DATA, W_ISSUE, W_WAIT, R_ISSUE, R_WAIT, RESP, DRAIN.
- `s_axis_tready` = 1 only in HDR, ADDR, DATA and DRAIN.
- HDR: an accepted beat latches op and wstrb and goes to ADDR. If that beat has `tlast`=1: `err_cnt`+1, stay in HDR.
- ADDR: an accepted beat latches the address.
  - Read with `tlast`=1 → R_ISSUE.
  - Read with `tlast`=0 → `err_cnt`+1, go to DRAIN.
  - Write with `tlast`=0 → DATA.
  - Write with `tlast`=1 → `err_cnt`+1, go to HDR.
- DATA: an accepted beat latches wdata.
  - `tlast`=1 → W_ISSUE.
  - `tlast`=0 → `err_cnt`+1, go to DRAIN.
- DRAIN: accept and discard beats until a beat with `tlast`=1 is accepted, then go to HDR.
- W_ISSUE: `bk_wstart`=1 for exactly one cycle → W_WAIT. The `bk_waddr`, `bk_wdata` and `bk_wstrb` registers stay stable from W_ISSUE until the next command is latched.
- W_WAIT: `bk_wdone` → HDR. A write produces no response beat.
- R_ISSUE: `bk_rstart`=1 for one cycle → R_WAIT.
- R_WAIT: `bk_rdone` → load `m_axis_tdata` from `bk_rdata` and go to RESP.
- RESP: `m_axis_tvalid`=1, with data held, until `m_axis_tready`=1, then go to HDR.
- Only one command is outstanding at a time. `bk_wstart` and `bk_rstart` are never high in the same cycle.
- `bk_wdone` or `bk_rdone` arriving in any state other than the matching wait state is ignored.
- `err_cnt` increments by at most 1 per frame and holds at 255.
- Output reset values:
  - All outputs 0.
  - FSM in HDR.
  - `s_axis_tready` = 1 from the first cycle after reset release.

## Timing
- `s_axis_tready` is a registered function of state. Handshake on `tvalid & tready` at the rising edge.
- From the accepting edge of the last beat:
  - `bk_wstart`/`bk_rstart` is high in the next cycle.
  - The start cycle is followed by the wait state.
- Read response: `m_axis_tvalid` rises in the cycle after `bk_rdone` is sampled.
- With `m_axis_tready` tied high, one read takes 2 beats + 1 issue cycle + master latency + 1 response cycle. The block returns to HDR one cycle after the response handshake.
- Back-to-back commands:
  - A header can be accepted in the cycle after the `bk_wdone` edge.
  - After a read, a header can be accepted in the cycle after the RESP handshake.
- Reset mid-operation:
  - All state clears immediately (asynchronously).
  - A pending response is discarded.
  - A partially received frame is lost; its remaining beats are parsed as a new frame.

## Test plan
- Write frame {0x8000_000F, 0x3000_0010, 0xDEAD_BEEF}:
  - One `bk_wstart` pulse with addr 0x3000_0010, data 0xDEAD_BEEF, strb 0xF.
  - No m_axis beat.
  - `busy` low again the cycle after `bk_wdone`.
- Read frame {0x0000_0000, 0x3000_0020}, with the slave returning 0x1234_5678:
  - One `bk_rstart` with raddr 0x3000_0020.
  - One m_axis beat with data 0x1234_5678 and tlast=1.
- Response backpressure: hold `m_axis_tready`=0 for 10 cycles during a read:
  - `tvalid` stays high and data stays stable.
  - `s_axis_tready` stays 0.
  - The next frame is accepted only after the handshake.
- Malformed frames:
  - Read frame whose address beat has `tlast`=0, followed by 2 junk beats with `tlast` on the second: both junk beats are drained, `err_cnt`=1, no `bk_*` strobe.
  - 1-beat frame: `err_cnt`=2.
- Saturation: 260 malformed 1-beat frames → `err_cnt`=255.
- Reset mid-operation: assert `axi_aresetn` low in R_WAIT:
  - All outputs 0 immediately.
  - The late `bk_rdone` after reset is ignored and produces no m_axis beat.

Source files
------------

// File: rtl/axis_cmd_bridge.sv
// ---------------------------------------------------------------------------
// axis_cmd_bridge
// Command front-end for axilite_master. Parses register-access commands that
// arrive as AXI-Stream frames and issues one backend write or read at a time
// over the bk_* strobe interface. Read data comes back as a single-beat
// AXI-Stream response.
//
// Frame layout (one 32-bit beat each):
//   beat 0 : header   [31] op (1 = write, 0 = read), [3:0] wstrb
//   beat 1 : address
//   beat 2 : write data (write frames only)
// A read frame is exactly 2 beats and a write frame exactly 3 beats, with
// tlast set only on the final beat. Anything else is counted in err_cnt.
//
// Ports:
//   axi_aclk, axi_aresetn       clock, async active-low reset
//   s_axis_*                    command stream in (tdata/tvalid/tlast/tready)
//   m_axis_*                    read response stream out (tlast == tvalid)
//   bk_wstart/waddr/wdata/wstrb write request to the backend master
//   bk_wdone                    write completion pulse from the master
//   bk_rstart/raddr             read request to the backend master
//   bk_rdata/bk_rdone           read data and completion pulse
//   busy                        high whenever the FSM is not in HDR
//   err_cnt                     saturating count of malformed frames
// ---------------------------------------------------------------------------
module axis_cmd_bridge (
   input  logic        axi_aclk,
   input  logic        axi_aresetn,
   // command stream
   input  logic [31:0] s_axis_tdata,
   input  logic        s_axis_tvalid,
   input  logic        s_axis_tlast,
   output logic        s_axis_tready,
   // response stream
   output logic [31:0] m_axis_tdata,
   output logic        m_axis_tvalid,
   output logic        m_axis_tlast,
   input  logic        m_axis_tready,
   // backend write
   output logic        bk_wstart,
   output logic [31:0] bk_waddr,
   output logic [31:0] bk_wdata,
   output logic [3:0]  bk_wstrb,
   input  logic        bk_wdone,
   // backend read
   output logic        bk_rstart,
   output logic [31:0] bk_raddr,
   input  logic [31:0] bk_rdata,
   input  logic        bk_rdone,
   // status
   output logic        busy,
   output logic [7:0]  err_cnt
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned STRB_W = 4;
   localparam int unsigned CNT_W  = 8;
   localparam int unsigned OP_BIT = 31;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [3:0] {
      HDR,
      ADDR,
      DATA,
      W_ISSUE,
      W_WAIT,
      R_ISSUE,
      R_WAIT,
      RESP,
      DRAIN
   } state_t;

   state_t              state;
   logic                hdr_op;
   logic [STRB_W-1:0]   hdr_strb;
   logic [DATA_W-1:0]   cmd_addr;

   logic                s_accept;
   logic [CNT_W-1:0]    err_inc;

   // Beat handshake on the registered ready.
   assign s_accept = s_axis_tvalid & s_axis_tready;

   // Saturating error-count increment.
   assign err_inc = (err_cnt == CNT_MAX) ? err_cnt : err_cnt + CNT_W'(1);

   // Command FSM. s_axis_tready and busy are registered alongside the state
   // so that each transition also sets their value for the destination state.
   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state         <= HDR;
         hdr_op        <= 1'b0;
         hdr_strb      <= '0;
         cmd_addr      <= '0;
         s_axis_tready <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         bk_wstart     <= 1'b0;
         bk_waddr      <= '0;
         bk_wdata      <= '0;
         bk_wstrb      <= '0;
         bk_rstart     <= 1'b0;
         bk_raddr      <= '0;
         busy          <= 1'b0;
         err_cnt       <= '0;
      end else begin
         // Start strobes are single-cycle pulses.
         bk_wstart <= 1'b0;
         bk_rstart <= 1'b0;

         unique case (state)
            HDR: begin
               s_axis_tready <= 1'b1;
               busy          <= 1'b0;
               if (s_accept) begin
                  hdr_op   <= s_axis_tdata[OP_BIT];
                  hdr_strb <= s_axis_tdata[STRB_W-1:0];
                  if (s_axis_tlast) begin
                     // A lone header is a complete (malformed) frame.
                     err_cnt <= err_inc;
                  end else begin
                     state <= ADDR;
                     busy  <= 1'b1;
                  end
               end
            end

            ADDR: begin
               if (s_accept) begin
                  if (!hdr_op) begin
                     if (s_axis_tlast) begin
                        bk_raddr      <= s_axis_tdata;
                        bk_rstart     <= 1'b1;
                        s_axis_tready <= 1'b0;
                        state         <= R_ISSUE;
                     end else begin
                        err_cnt <= err_inc;
                        state   <= DRAIN;
                     end
                  end else begin
                     if (!s_axis_tlast) begin
                        cmd_addr <= s_axis_tdata;
                        state    <= DATA;
                     end else begin
                        // Write frame ended early; the frame is already closed.
                        err_cnt <= err_inc;
                        busy    <= 1'b0;
                        state   <= HDR;
                     end
                  end
               end
            end

            DATA: begin
               if (s_accept) begin
                  if (s_axis_tlast) begin
                     // Backend write registers only change on a complete frame.
                     bk_waddr      <= cmd_addr;
                     bk_wdata      <= s_axis_tdata;
                     bk_wstrb      <= hdr_strb;
                     bk_wstart     <= 1'b1;
                     s_axis_tready <= 1'b0;
                     state         <= W_ISSUE;
                  end else begin
                     err_cnt <= err_inc;
                     state   <= DRAIN;
                  end
               end
            end

            DRAIN: begin
               if (s_accept && s_axis_tlast) begin
                  busy  <= 1'b0;
                  state <= HDR;
               end
            end

            W_ISSUE: begin
               state <= W_WAIT;
            end

            W_WAIT: begin
               if (bk_wdone) begin
                  s_axis_tready <= 1'b1;
                  busy          <= 1'b0;
                  state         <= HDR;
               end
            end

            R_ISSUE: begin
               state <= R_WAIT;
            end

            R_WAIT: begin
               if (bk_rdone) begin
                  m_axis_tdata  <= bk_rdata;
                  m_axis_tvalid <= 1'b1;
                  m_axis_tlast  <= 1'b1;
                  state         <= RESP;
               end
            end

            RESP: begin
               // Data is held until the downstream consumer takes it.
               if (m_axis_tready) begin
                  m_axis_tvalid <= 1'b0;
                  m_axis_tlast  <= 1'b0;
                  s_axis_tready <= 1'b1;
                  busy          <= 1'b0;
                  state         <= HDR;
               end
            end

            default: begin
               s_axis_tready <= 1'b1;
               busy          <= 1'b0;
               state         <= HDR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_cmd_bridge.sv
// ---------------------------------------------------------------------------
// tb_axis_cmd_bridge
// Scoreboard bench for axis_cmd_bridge. Stimulus pushes the expected backend
// requests and response beats into queues; a negedge monitor pops and compares
// whenever the DUT presents a start strobe or a response handshake. A simple
// backend model answers start strobes with done pulses after a fixed latency.
// ---------------------------------------------------------------------------
module tb_axis_cmd_bridge;

   localparam int W_LAT = 3;
   localparam int R_LAT = 6;
   localparam int BOUND = 200;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } wr_t;

   logic        axi_aclk = 1'b0;
   logic        axi_aresetn;
   logic [31:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tlast;
   logic        s_axis_tready;
   logic [31:0] m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tlast;
   logic        m_axis_tready;
   logic        bk_wstart;
   logic [31:0] bk_waddr;
   logic [31:0] bk_wdata;
   logic [3:0]  bk_wstrb;
   logic        bk_wdone;
   logic        bk_rstart;
   logic [31:0] bk_raddr;
   logic [31:0] bk_rdata;
   logic        bk_rdone;
   logic        busy;
   logic [7:0]  err_cnt;

   int checks   = 0;
   int failures = 0;

   wr_t         wr_q[$];
   logic [31:0] rd_q[$];
   logic [31:0] rsp_q[$];
   wr_t         mon_w;
   logic [31:0] mon_d;

   logic [31:0] slave_rdata = 32'h0;
   int          wpend = 0;
   int          rpend = 0;

   always #5 axi_aclk = ~axi_aclk;

   axis_cmd_bridge dut (
      .axi_aclk      (axi_aclk),
      .axi_aresetn   (axi_aresetn),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tready (m_axis_tready),
      .bk_wstart     (bk_wstart),
      .bk_waddr      (bk_waddr),
      .bk_wdata      (bk_wdata),
      .bk_wstrb      (bk_wstrb),
      .bk_wdone      (bk_wdone),
      .bk_rstart     (bk_rstart),
      .bk_raddr      (bk_raddr),
      .bk_rdata      (bk_rdata),
      .bk_rdone      (bk_rdone),
      .busy          (busy),
      .err_cnt       (err_cnt)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void fail_now(input string name, input string what);
      checks++;
      failures++;
      $display("FAIL %s: %s at %0t", name, what, $time);
   endfunction

   // Backend model: done pulse a fixed number of cycles after each start.
   initial begin
      bk_wdone = 1'b0;
      bk_rdone = 1'b0;
      bk_rdata = 32'hBAD0_BAD0;
      forever begin
         @(posedge axi_aclk);
         #1;
         bk_wdone = 1'b0;
         bk_rdone = 1'b0;
         bk_rdata = 32'hBAD0_BAD0;
         if (bk_wstart) wpend = W_LAT;
         else if (wpend > 0) begin
            wpend--;
            if (wpend == 0) bk_wdone = 1'b1;
         end
         if (bk_rstart) rpend = R_LAT;
         else if (rpend > 0) begin
            rpend--;
            if (rpend == 0) begin
               bk_rdone = 1'b1;
               bk_rdata = slave_rdata;
            end
         end
      end
   end

   // Monitor: pop and compare on every strobe / response handshake.
   always @(negedge axi_aclk) begin
      if (axi_aresetn) begin
         if (bk_wstart || bk_rstart)
            chk("start_exclusive", 32'(bk_wstart & bk_rstart), 32'h0);
         if (bk_wstart) begin
            if (wr_q.size() == 0) fail_now("unexpected_wstart", $sformatf("got addr 0x%08h expected no write", bk_waddr));
            else begin
               mon_w = wr_q.pop_front();
               chk("bk_waddr", bk_waddr, mon_w.addr);
               chk("bk_wdata", bk_wdata, mon_w.data);
               chk("bk_wstrb", 32'(bk_wstrb), 32'(mon_w.strb));
            end
         end
         if (bk_rstart) begin
            if (rd_q.size() == 0) fail_now("unexpected_rstart", $sformatf("got addr 0x%08h expected no read", bk_raddr));
            else begin
               mon_d = rd_q.pop_front();
               chk("bk_raddr", bk_raddr, mon_d);
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (rsp_q.size() == 0) fail_now("unexpected_resp", $sformatf("got data 0x%08h expected no beat", m_axis_tdata));
            else begin
               mon_d = rsp_q.pop_front();
               chk("m_axis_tdata", m_axis_tdata, mon_d);
               chk("m_axis_tlast", 32'(m_axis_tlast), 32'h1);
            end
         end
      end
   end

   task automatic send_beat(input logic [31:0] d, input logic last);
      int   n  = 0;
      logic ok = 1'b0;
      s_axis_tdata  = d;
      s_axis_tlast  = last;
      s_axis_tvalid = 1'b1;
      do begin
         ok = s_axis_tready;
         @(posedge axi_aclk);
         #1;
         n++;
      end while (!ok && n < BOUND);
      if (!ok) fail_now("send_timeout", $sformatf("beat 0x%08h not accepted", d));
   endtask

   task automatic end_frame();
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic wait_wdone();
      int n = 0;
      do begin
         @(negedge axi_aclk);
         n++;
      end while (!bk_wdone && n < BOUND);
      if (!bk_wdone) fail_now("wdone_timeout", "no bk_wdone seen");
   endtask

   task automatic wait_rdone();
      int n = 0;
      do begin
         @(negedge axi_aclk);
         n++;
      end while (!bk_rdone && n < BOUND);
      if (!bk_rdone) fail_now("rdone_timeout", "no bk_rdone seen");
   endtask

   task automatic wait_drain();
      int n = 0;
      do begin
         @(negedge axi_aclk);
         n++;
      end while ((busy || wr_q.size() != 0 || rd_q.size() != 0 || rsp_q.size() != 0) && n < BOUND);
      if (busy) fail_now("drain_timeout", "block still busy");
   endtask

   // Watchdog.
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic tv_seen;
      logic late_seen;

      axi_aresetn   = 1'b0;
      s_axis_tdata  = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
      m_axis_tready = 1'b1;

      // Reset state.
      repeat (3) @(posedge axi_aclk);
      #1;
      chk("rst_s_tready", 32'(s_axis_tready), 32'h0);
      chk("rst_busy",     32'(busy),          32'h0);
      chk("rst_err_cnt",  32'(err_cnt),       32'h0);
      chk("rst_m_tvalid", 32'(m_axis_tvalid), 32'h0);
      @(negedge axi_aclk);
      axi_aresetn = 1'b1;
      @(posedge axi_aclk);
      #1;
      chk("s_tready_after_rst", 32'(s_axis_tready), 32'h1);

      // Plain write.
      wr_q.push_back('{addr: 32'h3000_0010, data: 32'hDEAD_BEEF, strb: 4'hF});
      send_beat(32'h8000_000F, 1'b0);
      send_beat(32'h3000_0010, 1'b0);
      send_beat(32'hDEAD_BEEF, 1'b1);
      end_frame();
      chk("wstart_next_cycle", 32'(bk_wstart), 32'h1);
      chk("w_s_tready_low",    32'(s_axis_tready), 32'h0);
      wait_wdone();
      @(negedge axi_aclk);
      chk("busy_after_wdone",     32'(busy),          32'h0);
      chk("s_tready_after_wdone", 32'(s_axis_tready), 32'h1);

      // Plain read.
      slave_rdata = 32'h1234_5678;
      rd_q.push_back(32'h3000_0020);
      rsp_q.push_back(32'h1234_5678);
      send_beat(32'h0000_0000, 1'b0);
      send_beat(32'h3000_0020, 1'b1);
      end_frame();
      chk("rstart_next_cycle", 32'(bk_rstart), 32'h1);
      wait_rdone();
      @(negedge axi_aclk);
      chk("tvalid_after_rdone", 32'(m_axis_tvalid), 32'h1);
      @(posedge axi_aclk);
      #1;
      chk("busy_after_resp", 32'(busy), 32'h0);

      // Read with response backpressure, next frame offered meanwhile.
      // Reserved header bits set on both frames.
      m_axis_tready = 1'b0;
      slave_rdata   = 32'hA5A5_0F0F;
      rd_q.push_back(32'h3000_0040);
      rsp_q.push_back(32'hA5A5_0F0F);
      send_beat(32'h7FFF_FFF0, 1'b0);
      send_beat(32'h3000_0040, 1'b1);
      end_frame();
      wr_q.push_back('{addr: 32'h3000_0050, data: 32'h0BAD_F00D, strb: 4'h3});
      fork
         begin
            send_beat(32'hFFFF_FFF3, 1'b0);
            send_beat(32'h3000_0050, 1'b0);
            send_beat(32'h0BAD_F00D, 1'b1);
            end_frame();
         end
         begin
            int n = 0;
            do begin
               @(negedge axi_aclk);
               n++;
            end while (!m_axis_tvalid && n < BOUND);
            if (!m_axis_tvalid) fail_now("resp_timeout", "no m_axis_tvalid");
            for (int i = 0; i < 10; i++) begin
               @(negedge axi_aclk);
               chk("bp_tvalid",   32'(m_axis_tvalid), 32'h1);
               chk("bp_tdata",    m_axis_tdata,       32'hA5A5_0F0F);
               chk("bp_s_tready", 32'(s_axis_tready), 32'h0);
            end
            @(posedge axi_aclk);
            #1;
            m_axis_tready = 1'b1;
         end
      join
      wait_drain();

      // Malformed read: address beat without tlast, then two junk beats.
      send_beat(32'h0000_0000, 1'b0);
      send_beat(32'h3000_0030, 1'b0);
      send_beat(32'h1111_1111, 1'b0);
      send_beat(32'h2222_2222, 1'b1);
      end_frame();
      chk("err_malformed_read", 32'(err_cnt), 32'h1);
      chk("busy_after_drain",   32'(busy),    32'h0);

      // Parser realigned: a valid read goes through.
      slave_rdata = 32'hCAFE_F00D;
      rd_q.push_back(32'h3000_0060);
      rsp_q.push_back(32'hCAFE_F00D);
      send_beat(32'h0000_0000, 1'b0);
      send_beat(32'h3000_0060, 1'b1);
      end_frame();
      wait_drain();

      // One-beat frame.
      send_beat(32'h8000_000F, 1'b1);
      end_frame();
      chk("err_one_beat", 32'(err_cnt), 32'h2);

      // Write frame ending on the address beat.
      send_beat(32'h8000_000F, 1'b0);
      send_beat(32'h3000_0070, 1'b1);
      end_frame();
      chk("err_short_write",  32'(err_cnt), 32'h3);
      chk("busy_short_write", 32'(busy),    32'h0);

      // Write frame whose data beat lacks tlast, one junk beat drained.
      send_beat(32'h8000_000F, 1'b0);
      send_beat(32'h3000_0070, 1'b0);
      send_beat(32'h5555_5555, 1'b0);
      send_beat(32'h6666_6666, 1'b1);
      end_frame();
      chk("err_long_write", 32'(err_cnt), 32'h4);

      // Saturation with 260 one-beat frames.
      for (int i = 0; i < 250; i++) send_beat(32'h0000_0000, 1'b1);
      end_frame();
      chk("err_254", 32'(err_cnt), 32'd254);
      send_beat(32'h0000_0000, 1'b1);
      end_frame();
      chk("err_255", 32'(err_cnt), 32'd255);
      for (int i = 0; i < 9; i++) send_beat(32'h0000_0000, 1'b1);
      end_frame();
      chk("err_saturated", 32'(err_cnt), 32'd255);

      // Reset during R_WAIT; the late bk_rdone must be ignored.
      slave_rdata = 32'h5555_AAAA;
      rd_q.push_back(32'h3000_0080);
      send_beat(32'h0000_0000, 1'b0);
      send_beat(32'h3000_0080, 1'b1);
      end_frame();
      @(posedge axi_aclk);
      #1;
      @(negedge axi_aclk);
      axi_aresetn = 1'b0;
      #1;
      chk("mid_rst_s_tready", 32'(s_axis_tready), 32'h0);
      chk("mid_rst_m_tvalid", 32'(m_axis_tvalid), 32'h0);
      chk("mid_rst_m_tlast",  32'(m_axis_tlast),  32'h0);
      chk("mid_rst_m_tdata",  m_axis_tdata,       32'h0);
      chk("mid_rst_wstart",   32'(bk_wstart),     32'h0);
      chk("mid_rst_rstart",   32'(bk_rstart),     32'h0);
      chk("mid_rst_waddr",    bk_waddr,           32'h0);
      chk("mid_rst_wdata",    bk_wdata,           32'h0);
      chk("mid_rst_wstrb",    32'(bk_wstrb),      32'h0);
      chk("mid_rst_raddr",    bk_raddr,           32'h0);
      chk("mid_rst_busy",     32'(busy),          32'h0);
      chk("mid_rst_err_cnt",  32'(err_cnt),       32'h0);
      @(negedge axi_aclk);
      @(negedge axi_aclk);
      axi_aresetn = 1'b1;
      tv_seen   = 1'b0;
      late_seen = 1'b0;
      for (int i = 0; i < 15; i++) begin
         @(negedge axi_aclk);
         if (m_axis_tvalid) tv_seen = 1'b1;
         if (bk_rdone)      late_seen = 1'b1;
      end
      chk("late_rdone_issued",  32'(late_seen), 32'h1);
      chk("no_resp_after_rst",  32'(tv_seen),   32'h0);
      chk("busy_after_rst",     32'(busy),      32'h0);

      // Normal operation after the reset.
      wr_q.push_back('{addr: 32'h3000_0090, data: 32'h0000_00A5, strb: 4'h1});
      send_beat(32'h8000_0001, 1'b0);
      send_beat(32'h3000_0090, 1'b0);
      send_beat(32'h0000_00A5, 1'b1);
      end_frame();
      wait_drain();
      repeat (3) @(negedge axi_aclk);

      chk("scoreboard_empty", 32'(wr_q.size() + rd_q.size() + rsp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
